sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO. It is the next generation of the fixed 8x8 FIFO used by the block-level testbenches, with configurable width and depth and programmable almost-full/almost-empty thresholds. It adds an occupancy count output and sticky overflow/underflow error flags. It keeps the existing control-signal naming so that the existing assertion set can bind to it unchanged.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_mem_2p.sv | 27 ++
 rtl/sync_fifo_param.sv | 115 +++++++++++
 tb/tb_sync_fifo_param.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter-legality checks
// for the parametrised synchronous FIFO.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int lvl, input int depth);
    return (lvl >= 1) && (lvl <= depth);
  endfunction

  function automatic bit ae_ok(input int lvl, input int depth);
    return (lvl >= 0) && (lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// WIDTH x DEPTH register array: synchronous write,
// asynchronous read, no reset.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [ptr_w(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic [ptr_w(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]        rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count,
// programmable thresholds and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    fifo_write,
  input  logic [WIDTH-1:0]        fifo_data_in,
  input  logic                    fifo_read,
  output logic [WIDTH-1:0]        fifo_data_out,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    fifo_almost_full,
  output logic                    fifo_almost_empty,
  output logic [cnt_w(DEPTH)-1:0] fifo_cnt,
  output logic                    fifo_overflow,
  output logic                    fifo_underflow,
  input  logic                    clr_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: WIDTH must be >= 1");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!af_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range");
  end
  if (!ae_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL out of range");
  end

  // Names kept un-suffixed so existing bound assertions still resolve.
  logic [PW-1:0] rd_ptr, rd_ptr_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [CW-1:0] cnt, cnt_d;

  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic wr_ok, rd_ok;
  logic [WIDTH-1:0] rdata;

  always_comb begin
    wr_ok    = fifo_write && (!fifo_full || fifo_read);
    rd_ok    = fifo_read && !fifo_empty;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    cnt_d    = cnt;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr + PW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr + PW'(1);
    end
    unique case (1'b1)
      (wr_ok && !rd_ok): cnt_d = cnt + CW'(1);
      (rd_ok && !wr_ok): cnt_d = cnt - CW'(1);
      default:           cnt_d = cnt;
    endcase
  end

  // A fresh error in the clearing cycle wins over clr_err.
  always_comb begin
    ovf_d = (ovf_q && !clr_err) || (fifo_write && !wr_ok);
    udf_d = (udf_q && !clr_err) || (fifo_read && !rd_ok);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_d;
      wr_ptr <= wr_ptr_d;
      cnt    <= cnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr),
    .wdata_i (fifo_data_in),
    .raddr_i (rd_ptr),
    .rdata_o (rdata)
  );

  assign fifo_full         = (cnt == CW'(DEPTH));
  assign fifo_empty        = (cnt == '0);
  assign fifo_almost_full  = (cnt >= CW'(AF_LEVEL));
  assign fifo_almost_empty = (cnt <= CW'(AE_LEVEL));
  assign fifo_cnt          = cnt;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = udf_q;
  assign fifo_data_out     = fifo_empty ? '0 : rdata;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed steps plus random
// traffic checked against queue-based reference models.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       w_a = 1'b0, r_a = 1'b0, clr_a = 1'b0;
  logic [7:0] d_a = '0;
  logic [7:0] a_dout;
  logic [3:0] a_cnt;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;

  logic        rst_b = 1'b1;
  logic        w_b = 1'b0, r_b = 1'b0, clr_b = 1'b0;
  logic [31:0] d_b = '0;
  logic [31:0] b_dout;
  logic [4:0]  b_cnt;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;

  sync_fifo_param #(
    .WIDTH (8),
    .DEPTH (8)
  ) fi1 (
    .clk               (clk),
    .rst_              (rst_a),
    .fifo_write        (w_a),
    .fifo_data_in      (d_a),
    .fifo_read         (r_a),
    .fifo_data_out     (a_dout),
    .fifo_full         (a_full),
    .fifo_empty        (a_empty),
    .fifo_almost_full  (a_af),
    .fifo_almost_empty (a_ae),
    .fifo_cnt          (a_cnt),
    .fifo_overflow     (a_ovf),
    .fifo_underflow    (a_udf),
    .clr_err           (clr_a)
  );

  sync_fifo_param #(
    .WIDTH    (32),
    .DEPTH    (16),
    .AF_LEVEL (12),
    .AE_LEVEL (3)
  ) fi2 (
    .clk               (clk),
    .rst_              (rst_b),
    .fifo_write        (w_b),
    .fifo_data_in      (d_b),
    .fifo_read         (r_b),
    .fifo_data_out     (b_dout),
    .fifo_full         (b_full),
    .fifo_empty        (b_empty),
    .fifo_almost_full  (b_af),
    .fifo_almost_empty (b_ae),
    .fifo_cnt          (b_cnt),
    .fifo_overflow     (b_ovf),
    .fifo_underflow    (b_udf),
    .clr_err           (clr_b)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  qa[$];
  logic [31:0] qb[$];
  int wa = 0, ra = 0, wb = 0, rb = 0;
  bit ova = 0, uda = 0, ovb = 0, udb = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_a();
    bit full, wok, rok;
    full = (qa.size() == 8);
    wok  = w_a && (!full || r_a);
    rok  = r_a && (qa.size() != 0);
    ova  = (ova && !clr_a) || (w_a && !wok);
    uda  = (uda && !clr_a) || (r_a && !rok);
    if (rok) begin
      void'(qa.pop_front());
      ra++;
    end
    if (wok) begin
      qa.push_back(d_a);
      wa++;
    end
  endtask

  task automatic model_b();
    bit full, wok, rok;
    full = (qb.size() == 16);
    wok  = w_b && (!full || r_b);
    rok  = r_b && (qb.size() != 0);
    ovb  = (ovb && !clr_b) || (w_b && !wok);
    udb  = (udb && !clr_b) || (r_b && !rok);
    if (rok) begin
      void'(qb.pop_front());
      rb++;
    end
    if (wok) begin
      qb.push_back(d_b);
      wb++;
    end
  endtask

  task automatic check_a();
    int n;
    n = qa.size();
    chk("a_cnt", 64'(a_cnt), 64'(n));
    chk("a_empty", 64'(a_empty), 64'(n == 0));
    chk("a_full", 64'(a_full), 64'(n == 8));
    chk("a_afull", 64'(a_af), 64'(n >= 7));
    chk("a_aempty", 64'(a_ae), 64'(n <= 1));
    chk("a_dout", 64'(a_dout), (n != 0) ? 64'(qa[0]) : 64'd0);
    chk("a_ovf", 64'(a_ovf), 64'(ova));
    chk("a_udf", 64'(a_udf), 64'(uda));
    chk("a_wr_ptr", 64'(fi1.wr_ptr), 64'(wa % 8));
    chk("a_rd_ptr", 64'(fi1.rd_ptr), 64'(ra % 8));
  endtask

  task automatic check_b();
    int n;
    n = qb.size();
    chk("b_cnt", 64'(b_cnt), 64'(n));
    chk("b_empty", 64'(b_empty), 64'(n == 0));
    chk("b_full", 64'(b_full), 64'(n == 16));
    chk("b_afull", 64'(b_af), 64'(n >= 12));
    chk("b_aempty", 64'(b_ae), 64'(n <= 3));
    chk("b_dout", 64'(b_dout), (n != 0) ? 64'(qb[0]) : 64'd0);
    chk("b_ovf", 64'(b_ovf), 64'(ovb));
    chk("b_udf", 64'(b_udf), 64'(udb));
    chk("b_wr_ptr", 64'(fi2.wr_ptr), 64'(wb % 16));
    chk("b_rd_ptr", 64'(fi2.rd_ptr), 64'(rb % 16));
  endtask

  task automatic step();
    @(posedge clk);
    model_a();
    model_b();
    #1;
    check_a();
    check_b();
  endtask

  task automatic set_a(input logic w, input logic [7:0] d,
                       input logic r, input logic c);
    w_a = w; d_a = d; r_a = r; clr_a = c;
  endtask

  task automatic set_b(input logic w, input logic [31:0] d,
                       input logic r, input logic c);
    w_b = w; d_b = d; r_b = r; clr_b = c;
  endtask

  initial begin
    int pw, pr;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check_a();
    check_b();
    #10;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // fill 0x01..0x08, then drain
    for (int i = 1; i <= 8; i++) begin
      set_a(1'b1, 8'(i), 1'b0, 1'b0);
      step();
    end
    chk("a_full_after8", 64'(a_full), 64'd1);
    for (int i = 0; i < 8; i++) begin
      set_a(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    chk("a_empty_after_drain", 64'(a_empty), 64'd1);

    // overflow and clear
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step();
    end
    set_a(1'b1, 8'hAA, 1'b0, 1'b0);
    step();
    chk("a_ovf_set", 64'(a_ovf), 64'd1);
    set_a(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("a_ovf_clr", 64'(a_ovf), 64'd0);

    // underflow, then read+write on empty
    for (int i = 0; i < 8; i++) begin
      set_a(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    set_a(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("a_udf_set", 64'(a_udf), 64'd1);
    set_a(1'b1, 8'h55, 1'b1, 1'b0);
    step();
    chk("a_rw_empty_dout", 64'(a_dout), 64'h55);
    chk("a_rw_empty_cnt", 64'(a_cnt), 64'd1);

    // clear-vs-set: new underflow beats clr_err
    set_a(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    set_a(1'b0, 8'h00, 1'b1, 1'b1);
    step();
    chk("a_udf_set_wins", 64'(a_udf), 64'd1);
    set_a(1'b0, 8'h00, 1'b0, 1'b1);
    step();

    // wrap-around with interleaved traffic
    for (int i = 0; i < 12; i++) begin
      set_a(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step();
      set_a(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end

    // read+write at full
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
      step();
    end
    chk("a_rw_full_cnt", 64'(a_cnt), 64'd8);
    chk("a_rw_full_ovf", 64'(a_ovf), 64'd0);
    set_a(1'b0, 8'h00, 1'b0, 1'b0);

    // wide config: 5 words, async reset mid-cycle
    for (int i = 0; i < 5; i++) begin
      set_b(1'b1, $urandom, 1'b0, 1'b0);
      step();
    end
    set_b(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_b = 1'b0;
    #1;
    qb.delete();
    wb = 0; rb = 0; ovb = 0; udb = 0;
    check_b();
    #3;
    rst_b = 1'b1;
    set_b(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    chk("b_beef_dout", 64'(b_dout), 64'hDEADBEEF);
    chk("b_beef_cnt", 64'(b_cnt), 64'd1);
    set_b(1'b0, 32'h0, 1'b0, 1'b0);

    // randomized traffic in biased phases
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 80; i++) begin
        set_a($urandom_range(99) < pw, 8'($urandom),
              $urandom_range(99) < pr,
              $urandom_range(15) == 0);
        set_b($urandom_range(99) < pw, $urandom,
              $urandom_range(99) < pr,
              $urandom_range(15) == 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
